uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter (8N1, start/data/busy/done handshake) among NUM_REQ byte producers, such as an RX-echo path, a status reporter and a debug console. It grants one requester at a time and holds the grant for a multi-byte burst until the requester marks its last byte or MAX_BURST is reached. It sequences each byte into the transmitter and returns a per-requester accept pulse.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte handshake plus UART transmitter handshake bundle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] ack;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy;
  logic tx_done;
  logic [ID_W-1:0] owner;
  logic arb_busy;
  modport master(
    input req, req_data, req_last, tx_busy, tx_done,
    output ack, tx_start, tx_data, owner, arb_busy
  );
  modport slave(
    output req, req_data, req_last, tx_busy, tx_done,
    input ack, tx_start, tx_data, owner, arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] owner, owner_n, rr_last, rr_last_n, pick, cand;
  logic [7:0] tx_data, tx_data_n, burst_cnt, burst_cnt_n;
  logic [7:0] data [NUM_REQ];
  logic [NUM_REQ-1:0] ack, ack_n;
  logic tx_start, tx_start_n, arb_busy, arb_busy_n, lock, lock_n, found;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data[i] = bus.req_data[8*i +: 8];
  end
  // first pending requester after the previous grant holder, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_last_n = rr_last;
    tx_data_n = tx_data;
    burst_cnt_n = burst_cnt;
    ack_n = '0;
    tx_start_n = 1'b0;
    arb_busy_n = arb_busy;
    lock_n = lock;
    case (state)
      IDLE: if (found) begin
        owner_n = pick;
        tx_data_n = data[pick];
        lock_n = ~bus.req_last[pick];
        burst_cnt_n = 8'd1;
        ack_n[pick] = 1'b1;
        arb_busy_n = 1'b1;
        state_n = LAUNCH;
      end
      LAUNCH: if (!bus.tx_busy) begin
        tx_start_n = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: if (bus.tx_done) begin
        if (lock && bus.req[owner] && burst_cnt < 8'(MAX_BURST)) begin
          tx_data_n = data[owner];
          lock_n = ~bus.req_last[owner];
          ack_n[owner] = 1'b1;
          burst_cnt_n = burst_cnt + 8'd1;
          state_n = LAUNCH;
        end else begin
          rr_last_n = owner;
          arb_busy_n = 1'b0;
          burst_cnt_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr_last <= ID_W'(NUM_REQ - 1);
      tx_data <= '0;
      burst_cnt <= '0;
      ack <= '0;
      tx_start <= 1'b0;
      arb_busy <= 1'b0;
      lock <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_last <= rr_last_n;
      tx_data <= tx_data_n;
      burst_cnt <= burst_cnt_n;
      ack <= ack_n;
      tx_start <= tx_start_n;
      arb_busy <= arb_busy_n;
      lock <= lock_n;
    end
  end
  assign bus.ack = ack;
  assign bus.tx_start = tx_start;
  assign bus.tx_data = tx_data;
  assign bus.owner = owner;
  assign bus.arb_busy = arb_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-fed requesters, a simple transmitter model and an order-predicting reference
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus();
  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW), .MAX_BURST(MB)) dut(.clk(clk), .reset(reset), .bus(bus));
  logic [8:0] mem [N][64];
  int head [N];
  int tail [N];
  int tx_cnt, pend, proto_err, model_rr;
  bit force_busy, spur_done;
  int n_sent, n_exp;
  int sent_id [128];
  int exp_id [128];
  logic [7:0] sent_dat [128];
  logic [7:0] exp_dat [128];
  int pass_cnt, check_cnt;
  task automatic push(input int i, input logic [7:0] d, input bit l);
    mem[i][tail[i]] = {l, d};
    tail[i]++;
  endtask
  task automatic clear();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    n_sent = 0;
    proto_err = 0;
  endtask
  // one clock: observe DUT at the falling edge, run the transmitter, then drive requesters
  task automatic step();
    @(negedge clk);
    if (reset) pend = 0;
    else begin
      if ($countones(bus.ack) > 1) proto_err++;
      for (int i = 0; i < N; i++) if (bus.ack[i]) begin
        if (!bus.req[i]) proto_err++;
        if (head[i] < tail[i]) head[i]++;
        pend++;
      end
      if (pend > 1) proto_err++;
      if (bus.tx_start) begin
        if (bus.tx_busy || tx_cnt != 0 || pend != 1) proto_err++;
        pend--;
        if (n_sent < 128) begin
          sent_id[n_sent] = int'(bus.owner);
          sent_dat[n_sent] = bus.tx_data;
        end
        n_sent++;
      end
    end
    bus.tx_done = spur_done || tx_cnt == 1;
    if (tx_cnt > 0) tx_cnt--;
    if (bus.tx_start && !reset) tx_cnt = $urandom_range(6, 2);
    bus.tx_busy = force_busy || tx_cnt > 0;
    for (int i = 0; i < N; i++) begin
      bus.req[i] = head[i] < tail[i];
      bus.req_data[8*i +: 8] = (head[i] < tail[i]) ? mem[i][head[i]][7:0] : 8'h00;
      bus.req_last[i] = (head[i] < tail[i]) ? mem[i][head[i]][8] : 1'b0;
    end
  endtask
  function automatic bit quiet();
    quiet = !bus.arb_busy && tx_cnt == 0 && pend == 0 && !bus.tx_start;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) quiet = 1'b0;
  endfunction
  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      ok = quiet();
    end
  endtask
  // expected byte order: round-robin over non-empty queues, each grant sending until last, empty or MB bytes
  task automatic model_build();
    int h [N];
    int rr, pk, n;
    bit last, more;
    for (int i = 0; i < N; i++) h[i] = head[i];
    n_exp = 0;
    rr = model_rr;
    more = 1'b1;
    while (more) begin
      pk = -1;
      for (int k = 1; k <= N; k++) if (pk < 0 && h[(rr + k) % N] < tail[(rr + k) % N]) pk = (rr + k) % N;
      if (pk < 0) more = 1'b0;
      else begin
        n = 0;
        last = 1'b0;
        while (!last && n < MB && h[pk] < tail[pk]) begin
          exp_id[n_exp] = pk;
          exp_dat[n_exp] = mem[pk][h[pk]][7:0];
          last = mem[pk][h[pk]][8];
          h[pk]++;
          n_exp++;
          n++;
        end
        rr = pk;
      end
    end
    model_rr = rr;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    clear();
    step();
    step();
    reset = 1'b0;
    model_rr = N - 1;
  endtask
  task automatic test_reset();
    step();
    step();
    check_cnt++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", bus.ack); else pass_cnt++;
    check_cnt++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", bus.tx_start); else pass_cnt++;
    check_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", bus.tx_data); else pass_cnt++;
    check_cnt++; if (bus.owner !== 2'd0) $display("FAIL reset_owner got %0d want 0", bus.owner); else pass_cnt++;
    check_cnt++; if (bus.arb_busy !== 1'b0) $display("FAIL reset_arb_busy got %b want 0", bus.arb_busy); else pass_cnt++;
    reset = 1'b0;
    model_rr = N - 1;
    step();
  endtask
  task automatic test_single();
    bit ok;
    clear();
    push(1, 8'h41, 1'b1);
    model_build();
    step();
    step();
    check_cnt++; if (bus.ack !== 4'b0010) $display("FAIL single_ack got %b want 0010", bus.ack); else pass_cnt++;
    check_cnt++; if (bus.owner !== 2'd1 || bus.arb_busy !== 1'b1) $display("FAIL single_grant got owner %0d busy %b want 1 1", bus.owner, bus.arb_busy); else pass_cnt++;
    check_cnt++; if (bus.tx_start !== 1'b0) $display("FAIL single_early_start got %b want 0", bus.tx_start); else pass_cnt++;
    step();
    check_cnt++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h41) $display("FAIL single_start got %b/%h want 1/41", bus.tx_start, bus.tx_data); else pass_cnt++;
    check_cnt++; if (bus.ack !== 4'b0000) $display("FAIL single_ack_width got %b want 0000", bus.ack); else pass_cnt++;
    drain(50, ok);
    check_cnt++; if (!ok || bus.arb_busy !== 1'b0) $display("FAIL single_release got busy %b want 0", bus.arb_busy); else pass_cnt++;
    check_cnt++; if (n_sent !== 1 || sent_id[0] !== exp_id[0] || sent_dat[0] !== exp_dat[0]) $display("FAIL single_byte got %0d/%h want %0d/%h", sent_id[0], sent_dat[0], exp_id[0], exp_dat[0]); else pass_cnt++;
    clear();
    push(0, 8'h5A, 1'b1);
    push(2, 8'hA5, 1'b1);
    model_build();
    drain(100, ok);
    check_cnt++; if (!ok) $display("FAIL single_next_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== n_exp) $display("FAIL single_next_count got %0d want %0d", n_sent, n_exp); else pass_cnt++;
    for (int j = 0; j < n_exp && j < n_sent; j++) begin
      check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL single_next_byte%0d got %0d/%h want %0d/%h", j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
    end
    check_cnt++; if (proto_err !== 0) $display("FAIL single_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) push(i, 8'($urandom), 1'b1);
    model_build();
    drain(400, ok);
    check_cnt++; if (!ok) $display("FAIL rr_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== n_exp) $display("FAIL rr_count got %0d want %0d", n_sent, n_exp); else pass_cnt++;
    for (int j = 0; j < n_exp && j < n_sent; j++) begin
      check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL rr_byte%0d got %0d/%h want %0d/%h", j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
    end
    check_cnt++; if (proto_err !== 0) $display("FAIL rr_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_burst_lock();
    bit ok;
    clear();
    for (int b = 0; b < 4; b++) push(0, 8'h10 + 8'(b), b == 3);
    push(2, 8'h20, 1'b1);
    push(2, 8'h21, 1'b1);
    model_build();
    drain(400, ok);
    check_cnt++; if (!ok) $display("FAIL burst_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== n_exp) $display("FAIL burst_count got %0d want %0d", n_sent, n_exp); else pass_cnt++;
    for (int j = 0; j < n_exp && j < n_sent; j++) begin
      check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL burst_byte%0d got %0d/%h want %0d/%h", j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
    end
    check_cnt++; if (proto_err !== 0) $display("FAIL burst_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_max_burst();
    bit ok;
    clear();
    for (int b = 0; b < 20; b++) push(1, 8'h80 + 8'(b), 1'b0);
    for (int b = 0; b < 3; b++) push(3, 8'hE0 + 8'(b), 1'b1);
    model_build();
    drain(800, ok);
    check_cnt++; if (!ok) $display("FAIL maxb_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== n_exp) $display("FAIL maxb_count got %0d want %0d", n_sent, n_exp); else pass_cnt++;
    for (int j = 0; j < n_exp && j < n_sent; j++) begin
      check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL maxb_byte%0d got %0d/%h want %0d/%h", j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
    end
    check_cnt++; if (proto_err !== 0) $display("FAIL maxb_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_busy_holdoff();
    bit ok, got;
    int starts, acks;
    clear();
    force_busy = 1'b1;
    push(2, 8'hC3, 1'b0);
    push(2, 8'hC4, 1'b1);
    model_build();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      got = bus.ack[2];
    end
    check_cnt++; if (!got) $display("FAIL busy_grant got no ack want ack on 2"); else pass_cnt++;
    starts = 0;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      spur_done = c == 10;
      step();
      starts += int'(bus.tx_start);
      acks += $countones(bus.ack);
    end
    spur_done = 1'b0;
    check_cnt++; if (starts !== 0) $display("FAIL busy_holdoff got %0d starts want 0", starts); else pass_cnt++;
    check_cnt++; if (acks !== 0) $display("FAIL busy_spurious_done got %0d acks want 0", acks); else pass_cnt++;
    force_busy = 1'b0;
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      starts += int'(bus.tx_start);
    end
    check_cnt++; if (starts !== 1) $display("FAIL busy_release got %0d starts want 1", starts); else pass_cnt++;
    drain(200, ok);
    check_cnt++; if (!ok) $display("FAIL busy_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== n_exp) $display("FAIL busy_count got %0d want %0d", n_sent, n_exp); else pass_cnt++;
    for (int j = 0; j < n_exp && j < n_sent; j++) begin
      check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL busy_byte%0d got %0d/%h want %0d/%h", j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
    end
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check_cnt++; if (bus.ack !== 4'b0000 || bus.arb_busy !== 1'b0 || bus.tx_start !== 1'b0) $display("FAIL busy_idle_done got ack %b busy %b start %b want 0 0 0", bus.ack, bus.arb_busy, bus.tx_start); else pass_cnt++;
    check_cnt++; if (proto_err !== 0) $display("FAIL busy_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_drop_mid_burst();
    bit ok;
    clear();
    push(0, 8'h31, 1'b0);
    push(0, 8'h32, 1'b0);
    push(1, 8'h77, 1'b1);
    push(3, 8'h99, 1'b1);
    model_build();
    drain(300, ok);
    check_cnt++; if (!ok) $display("FAIL drop_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== n_exp) $display("FAIL drop_count got %0d want %0d", n_sent, n_exp); else pass_cnt++;
    for (int j = 0; j < n_exp && j < n_sent; j++) begin
      check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL drop_byte%0d got %0d/%h want %0d/%h", j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
    end
    check_cnt++; if (proto_err !== 0) $display("FAIL drop_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    bit ok, got;
    logic [7:0] d3;
    clear();
    push(2, 8'h61, 1'b0);
    push(2, 8'h62, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      got = bus.tx_start;
    end
    step();
    check_cnt++; if (!got || bus.arb_busy !== 1'b1) $display("FAIL rmid_setup got start %b busy %b want 1 1", got, bus.arb_busy); else pass_cnt++;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    reset = 1'b1;
    #1;
    check_cnt++; if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0) $display("FAIL rmid_pulses got ack %b start %b want 0000 0", bus.ack, bus.tx_start); else pass_cnt++;
    check_cnt++; if (bus.arb_busy !== 1'b0 || bus.owner !== 2'd0) $display("FAIL rmid_grant got busy %b owner %0d want 0 0", bus.arb_busy, bus.owner); else pass_cnt++;
    step();
    reset = 1'b0;
    model_rr = N - 1;
    clear();
    d3 = 8'($urandom);
    push(3, d3, 1'b1);
    model_build();
    drain(200, ok);
    check_cnt++; if (!ok) $display("FAIL rmid_timeout got busy want idle"); else pass_cnt++;
    check_cnt++; if (n_sent !== 1 || sent_id[0] !== 3 || sent_dat[0] !== d3) $display("FAIL rmid_req3 got %0d bytes %0d/%h want 1 3/%h", n_sent, sent_id[0], sent_dat[0], d3); else pass_cnt++;
    check_cnt++; if (proto_err !== 0) $display("FAIL rmid_protocol got %0d errors want 0", proto_err); else pass_cnt++;
  endtask
  task automatic test_random();
    bit ok;
    for (int r = 0; r < 6; r++) begin
      clear();
      for (int i = 0; i < N; i++) begin
        int k = $urandom_range(6, 0);
        for (int b = 0; b < k; b++) push(i, 8'($urandom), $urandom_range(2, 0) == 0);
      end
      model_build();
      drain(1500, ok);
      check_cnt++; if (!ok) $display("FAIL rand%0d_timeout got busy want idle", r); else pass_cnt++;
      check_cnt++; if (n_sent !== n_exp) $display("FAIL rand%0d_count got %0d want %0d", r, n_sent, n_exp); else pass_cnt++;
      for (int j = 0; j < n_exp && j < n_sent; j++) begin
        check_cnt++; if (sent_id[j] !== exp_id[j] || sent_dat[j] !== exp_dat[j]) $display("FAIL rand%0d_byte%0d got %0d/%h want %0d/%h", r, j, sent_id[j], sent_dat[j], exp_id[j], exp_dat[j]); else pass_cnt++;
      end
      check_cnt++; if (proto_err !== 0) $display("FAIL rand%0d_protocol got %0d errors want 0", r, proto_err); else pass_cnt++;
    end
  endtask
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    clear();
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_max_burst();
    test_busy_holdoff();
    test_drop_mid_burst();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
